// File: rtl/mux_scan_sequencer.sv
// Scan sequencer around a 4:1 select mux: steps the select lines through the
// enabled channels, waits for the mux to settle, and hands out a 4-bit sample word.
//
// state  | meaning
// IDLE   | waiting for start, select lines parked on channel 0
// SCAN   | one cycle per channel: skip masked channel or arm settle timer
// SETTLE | timer counting down; capture mux_out when it reaches zero
// DONE   | sample word valid, held until the consumer takes it
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic [3:0] enable_mask,
  output logic       addr0,
  output logic       addr1,
  input  logic       mux_out,
  output logic [3:0] sample_data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, SETTLE, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       ch, ch_nxt;
  logic [3:0]       mask_q, mask_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       data_q, data_nxt;
  logic             valid_q, valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 2'd0;
      mask_q  <= 4'd0;
      cnt     <= '0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      mask_q  <= mask_nxt;
      cnt     <= cnt_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    mask_nxt  = mask_q;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    case (state)
      IDLE: begin
        if (start) begin
          mask_nxt  = enable_mask;
          ch_nxt    = 2'd0;
          data_nxt  = 4'd0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (mask_q[ch]) begin
          cnt_nxt   = SETTLE_LOAD;
          state_nxt = SETTLE;
        end else begin
          data_nxt[ch] = 1'b0;
          if (ch == 2'd3) begin
            ch_nxt    = 2'd0;
            valid_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            ch_nxt = ch + 2'd1;
          end
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          data_nxt[ch] = mux_out;
          if (ch == 2'd3) begin
            ch_nxt    = 2'd0;
            valid_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            ch_nxt    = ch + 2'd1;
            state_nxt = SCAN;
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here; only the handshake moves us on
        if (ready) begin
          valid_nxt = 1'b0;
          if (continuous) begin
            mask_nxt  = enable_mask;
            ch_nxt    = 2'd0;
            data_nxt  = 4'd0;
            state_nxt = SCAN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign addr0       = ch[0];
  assign addr1       = ch[1];
  assign sample_data = data_q;
  assign valid       = valid_q;
  assign busy        = (state != IDLE);

endmodule
